eth_rx_preamble_sfd: RTL

ETH_RX_PREAMBLE_SFD -- requirements
Module: eth_rx_preamble_sfd

---
 rtl/eth_rx_preamble_sfd.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/eth_rx_preamble_sfd.sv
// GMII receive front end: hunts for preamble + SFD, forwards payload bytes (FCS included)
// one cycle later, and reports frame completion, abort and length.
module eth_rx_preamble_sfd #(
    parameter int MIN_PREAMBLE = 6,
    parameter int MAX_FRAME    = 1522
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        preamble_sfd_valid,
    output logic        frame_done,
    output logic        frame_error,
    output logic [10:0] frame_len
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [3:0]  PRE_SAT  = 4'hF;
    localparam logic [3:0]  MIN_PRE  = 4'(MIN_PREAMBLE);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        sof_q, sof_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [10:0] len_q, len_d;

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            pre_cnt_q    <= 4'd0;
            byte_cnt_q   <= 11'd0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            len_q        <= 11'd0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sof_q        <= sof_d;
            done_q       <= done_d;
            err_q        <= err_d;
            len_q        <= len_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        data_out_d   = 8'h00;
        data_valid_d = 1'b0;
        sof_d        = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        len_d        = len_q;

        case (state_q)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PRE_BYTE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d   = DROP;
                        pre_cnt_d = 4'd0;
                    end
                end else begin
                    pre_cnt_d = 4'd0;
                end
            end

            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (gmii_rx_er) begin
                    state_d = DROP;
                end else if (gmii_rxd == PRE_BYTE) begin
                    if (pre_cnt_q != PRE_SAT) begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end else begin
                        pre_cnt_d = pre_cnt_q;
                    end
                end else if ((gmii_rxd == SFD_BYTE) && (pre_cnt_q >= MIN_PRE)) begin
                    // SFD is consumed here and never forwarded.
                    state_d    = DATA;
                    byte_cnt_d = 11'd0;
                end else begin
                    state_d = DROP;
                end
            end

            DATA: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                    len_d   = byte_cnt_q;
                    // An SFD with no payload behind it is an abort, not a frame.
                    if (byte_cnt_q == 11'd0) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (gmii_rx_er || (byte_cnt_q == MAX_LEN)) begin
                    state_d = DROP;
                    err_d   = 1'b1;
                    len_d   = byte_cnt_q;
                end else begin
                    data_out_d   = gmii_rxd;
                    data_valid_d = 1'b1;
                    sof_d        = (byte_cnt_q == 11'd0);
                    byte_cnt_d   = byte_cnt_q + 11'd1;
                end
            end

            DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out           = data_out_q;
    assign data_valid         = data_valid_q;
    assign preamble_sfd_valid = sof_q;
    assign frame_done         = done_q;
    assign frame_error        = err_q;
    assign frame_len          = len_q;

endmodule
